sram_rd_streamer: RTL and testbench
===================================

SRAM_RD_STREAMER -- requirements
Module: sram_rd_streamer

Interface
REQ-001 SHALL have parameter AW, default 12, meaning SRAM address width.
REQ-002 SHALL have parameter DW, default 8, meaning SRAM data width (signed samples).
REQ-003 SHALL have parameter NLOG2, default 11, meaning FFT size log2; also the bit-reverse width.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  request a burst; sampled only in IDLE.
REQ-007 base_addr  in  AW  first SRAM address of the burst; captured at start.
REQ-008 count  in  AW  number of words; captured at start.
REQ-009 bitrev  in  1  1 = bit-reversed index order; captured at start.
REQ-010 busy  out  1  burst in progress.
REQ-011 done  out  1  one-cycle pulse at burst end.
REQ-012 sram_cs  out  1  SRAM chip select; registered.
REQ-013 sram_w  out  1  SRAM write enable; constant 0.
REQ-014 sram_addr  out  AW  SRAM address; registered.
REQ-015 sram_rdata  in  DW  SRAM read data; valid the 2nd cycle after the cycle sram_cs=1 is driven.
REQ-016 m_valid  out  1  output beat valid.
REQ-017 m_data  out  DW  output sample.
REQ-018 m_last  out  1  marks final beat.
REQ-019 m_ready  in  1  downstream accepts a beat when m_valid=1 and m_ready=1.

Function
REQ-020 The FSM SHALL have states IDLE, RUN (issuing reads) and DRAIN (all reads issued, data pending).
REQ-021 IDLE->RUN on start=1 with effective count N>0; N = min(count, 2^NLOG2).
REQ-022 start=1 with count=0 SHALL stay in IDLE, produce no beats and pulse done on the next cycle.
REQ-023 start SHALL be ignored outside IDLE.
REQ-024 Index i SHALL run 0..N-1; address = base_addr + (bitrev ? reverse of i[NLOG2-1:0] : i), modulo 2^AW.
REQ-025 A read SHALL issue (sram_cs=1 registered, sram_addr set) only when fifo_occupancy + in_flight < 4.
REQ-026 The output FIFO SHALL be 4 entries deep; sram_rdata SHALL be written 2 cycles after each issue.
REQ-027 RUN->DRAIN when read N-1 issues; DRAIN->IDLE on the handshake of the beat with m_last=1.
REQ-028 m_last SHALL be 1 only on the N-th beat.
REQ-029 m_data SHALL equal the SRAM word at the computed address, unmodified, in index order.
REQ-030 m_valid/m_data/m_last SHALL stay stable while m_valid=1 and m_ready=0.
REQ-031 Latency: start at cycle T -> sram_cs=1 in T+1 -> m_valid=1 in T+3.
REQ-032 With m_ready held 1, throughput SHALL be 1 beat per cycle; N beats complete in cycles T+3..T+N+2.
REQ-033 busy SHALL be 1 in RUN and DRAIN and 0 otherwise.
REQ-034 done SHALL pulse 1 for one cycle, the cycle after the last-beat handshake, with busy=0.
REQ-035 sram_cs SHALL be 0 in every cycle without an issue; sram_w SHALL always be 0.
REQ-036 No FIFO overflow SHALL occur under any m_ready pattern; no underflow SHALL occur (m_valid=0 when empty).

Reset
REQ-037 rst=1 SHALL force IDLE, FIFO empty, in_flight=0, and busy=done=sram_cs=sram_w=m_valid=m_last=0, sram_addr=0, m_data=0.
REQ-038 rst during RUN/DRAIN SHALL abort the burst; in-flight SRAM data SHALL be discarded; no done pulse.
REQ-039 rst SHALL take priority over start in the same cycle.

Verification
REQ-040 SRAM mem[k]=k-100 (as 8-bit), base=0, count=8, bitrev=0, m_ready=1 -> beats -100..-93, m_last on beat 8, m_valid at T+3, done at T+11.
REQ-041 base=0, count=2048, bitrev=1 -> beat order addresses 0,1024,512,1536,256,...; 2048 beats; last address 2047.
REQ-042 base=4094, count=4, bitrev=0 -> addresses 4094,4095,0,1 (wrap).
REQ-043 count=16, m_ready random 30% -> all 16 values in order, no loss or duplication, at most 4 outstanding reads+FIFO entries.
REQ-044 count=0 -> no sram_cs, no m_valid, done pulse at T+1; start during busy -> ignored, burst unchanged.
REQ-045 rst asserted mid-burst after 3 beats -> all outputs 0 next cycle; a new start then yields a clean, full burst.

Source files
------------

// File: rtl/sram_rd_streamer.sv
// sram_rd_streamer: reads a burst of N words from a synchronous SRAM in linear
// or bit-reversed index order and streams them out through a 4-entry FIFO
// with a valid/ready handshake. Reads are throttled so that reads in flight
// plus FIFO entries never exceed the FIFO depth.
module sram_rd_streamer #(
  parameter int AW    = 12,
  parameter int DW    = 8,
  parameter int NLOG2 = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] count,
  input  logic          bitrev,
  output logic          busy,
  output logic          done,
  output logic          sram_cs,
  output logic          sram_w,
  output logic [AW-1:0] sram_addr,
  input  logic [DW-1:0] sram_rdata,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  input  logic          m_ready
);

  // Index counter holds 0..2^NLOG2, so it needs one bit beyond the FFT width.
  localparam int IW = NLOG2 + 1;
  // Common width wide enough for both the count port and the index range.
  localparam int CW = (AW > IW) ? AW + 1 : IW + 1;
  localparam int FD = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t        state;
  logic [AW-1:0] base_q;
  logic          bitrev_q;
  logic [IW-1:0] n_q;
  logic [IW-1:0] idx;
  logic          last_issue;

  // Read pipeline: sram_cs marks stage 1, p2_valid marks the cycle the SRAM
  // word is on sram_rdata. The last-beat tag travels alongside.
  logic          p1_last;
  logic          p2_valid;
  logic          p2_last;

  // Output FIFO
  logic [DW-1:0] fifo_data [FD];
  logic          fifo_last [FD];
  logic [1:0]    wr_ptr;
  logic [1:0]    rd_ptr;
  logic [2:0]    occ;
  logic [2:0]    pending;
  logic          room;
  logic          pop;

  logic [CW-1:0] count_w;
  logic [CW-1:0] n_max_w;
  logic [IW-1:0] n_eff;

  // Address offset for index i: either i itself or i's low NLOG2 bits reversed.
  function automatic logic [AW-1:0] addr_offset(input logic [IW-1:0] i, input logic rev);
    logic [CW-1:0] wide;
    wide = '0;
    if (rev) begin
      for (int b = 0; b < NLOG2; b++) wide[b] = i[NLOG2-1-b];
    end else begin
      wide[IW-1:0] = i;
    end
    return wide[AW-1:0];
  endfunction

  // Effective burst length: count clamped to the FFT size.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    count_w = CW'(count);
    n_max_w = CW'(1) << NLOG2;
    n_eff   = (count_w > n_max_w) ? IW'(n_max_w) : IW'(count_w);
  end

  // Words issued but not yet popped must never exceed the FIFO depth.
  assign pending    = occ + {2'b00, sram_cs} + {2'b00, p2_valid};
  assign room       = (pending < 3'd4);
  assign last_issue = (idx == n_q - IW'(1));
  assign pop        = m_valid && m_ready;

  assign busy    = (state != S_IDLE);
  assign sram_w  = 1'b0;
  assign m_valid = (occ != 3'd0);
  assign m_data  = fifo_data[rd_ptr];
  assign m_last  = m_valid && fifo_last[rd_ptr];

  // Burst control FSM: captures the request, issues reads, tracks completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      base_q    <= '0;
      bitrev_q  <= 1'b0;
      n_q       <= '0;
      idx       <= '0;
      done      <= 1'b0;
      sram_cs   <= 1'b0;
      sram_addr <= '0;
      p1_last   <= 1'b0;
      p2_valid  <= 1'b0;
      p2_last   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      done     <= 1'b0;
      sram_cs  <= 1'b0;
      p2_valid <= sram_cs;
      p2_last  <= p1_last;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (n_eff == '0) begin
              done <= 1'b1;
            end else begin
              base_q    <= base_addr;
              bitrev_q  <= bitrev;
              n_q       <= n_eff;
              idx       <= IW'(1);
              sram_cs   <= 1'b1;
              sram_addr <= base_addr;
              p1_last   <= (n_eff == IW'(1));
              state     <= (n_eff == IW'(1)) ? S_DRAIN : S_RUN;
            end
          end
        end
        S_RUN: begin
          if (room) begin
            sram_cs   <= 1'b1;
            sram_addr <= base_q + addr_offset(idx, bitrev_q);
            p1_last   <= last_issue;
            idx       <= idx + IW'(1);
            if (last_issue) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop && m_last) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output FIFO: filled two cycles after each issue, drained by the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      // NOTE: storage is reset as well so m_data reads 0 out of reset; only 4 entries.
      for (int k = 0; k < FD; k++) begin
        fifo_data[k] <= '0;
        fifo_last[k] <= 1'b0;
      end
    end else begin
      if (p2_valid) begin
        fifo_data[wr_ptr] <= sram_rdata;
        fifo_last[wr_ptr] <= p2_last;
        wr_ptr            <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      occ <= occ + {2'b00, p2_valid} - {2'b00, pop};
    end
  end

endmodule

// File: tb/tb_sram_rd_streamer.sv
// Directed testbench for sram_rd_streamer with a 1-cycle synchronous SRAM model
// holding mem[k] = k-100 (8-bit).
module tb_sram_rd_streamer;

  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int NLOG2 = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] count = '0;
  logic          bitrev = 1'b0;
  logic          busy;
  logic          done;
  logic          sram_cs;
  logic          sram_w;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_rdata;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready;
  logic          rand_ready = 1'b0;

  logic [DW-1:0] mem [4096];
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;

  // Monitor records
  logic [AW-1:0] addr_q[$];
  int            addr_cyc_q[$];
  logic [DW-1:0] data_q[$];
  logic          last_q[$];
  int            beat_cyc_q[$];
  int            done_q[$];
  int            mv_cycles = 0;
  int            issued = 0;
  int            accepted = 0;
  int            max_out = 0;
  int            stab_err = 0;
  int            w_err = 0;
  int            done_busy_err = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  sram_rd_streamer #(.AW(AW), .DW(DW), .NLOG2(NLOG2)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .count      (count),
    .bitrev     (bitrev),
    .busy       (busy),
    .done       (done),
    .sram_cs    (sram_cs),
    .sram_w     (sram_w),
    .sram_addr  (sram_addr),
    .sram_rdata (sram_rdata),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_ready    (m_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous SRAM: word for the address presented with cs appears next cycle.
  always @(posedge clk) if (sram_cs) sram_rdata <= mem[sram_addr];

  // Downstream ready: held high, or high about 30% of cycles in random mode.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  // Mid-cycle monitor
  always @(negedge clk) begin
    if (sram_w) w_err++;
    if (rst) begin
      issued     = 0;
      accepted   = 0;
      prev_stall = 1'b0;
    end else begin
      if (sram_cs) begin
        addr_q.push_back(sram_addr);
        addr_cyc_q.push_back(cyc);
        issued++;
      end
      if (issued - accepted > max_out) max_out = issued - accepted;
      if (m_valid) mv_cycles++;
      if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last)) stab_err++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (m_valid && m_ready) begin
        data_q.push_back(m_data);
        last_q.push_back(m_last);
        beat_cyc_q.push_back(cyc);
        accepted++;
      end
      if (done) begin
        done_q.push_back(cyc);
        if (busy) done_busy_err++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] b, input int i, input logic br);
    logic [NLOG2-1:0] iv;
    logic [NLOG2-1:0] r;
    iv = i[NLOG2-1:0];
    for (int k = 0; k < NLOG2; k++) r[k] = iv[NLOG2-1-k];
    return br ? (b + AW'(r)) : (b + AW'(i));
  endfunction

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    return DW'(int'(a) - 100);
  endfunction

  task automatic start_burst(input logic [AW-1:0] b, input logic [AW-1:0] c, input logic br,
                             output int t0);
    @(posedge clk);
    #1;
    base_addr = b;
    count     = c;
    bitrev    = br;
    start     = 1'b1;
    t0        = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int limit, input string tag);
    int n;
    n = 0;
    while (done_q.size() <= d0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({tag, " done seen"}, 32'(done_q.size() > d0), 32'd1);
  endtask

  task automatic check_burst(input string tag, input int a0, input int b0, input int n,
                             input logic [AW-1:0] b, input logic br);
    check({tag, " issues"}, 32'(addr_q.size() - a0), 32'(n));
    check({tag, " beats"}, 32'(data_q.size() - b0), 32'(n));
    for (int k = 0; k < n && (a0 + k) < addr_q.size() && (b0 + k) < data_q.size(); k++) begin
      check($sformatf("%s addr%0d", tag, k), 32'(addr_q[a0+k]), 32'(exp_addr(b, k, br)));
      check($sformatf("%s data%0d", tag, k), 32'(data_q[b0+k]), 32'(exp_data(exp_addr(b, k, br))));
      check($sformatf("%s last%0d", tag, k), 32'(last_q[b0+k]), 32'(k == n - 1));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " sram_cs"}, 32'(sram_cs), 32'd0);
    check({tag, " sram_w"}, 32'(sram_w), 32'd0);
    check({tag, " sram_addr"}, 32'(sram_addr), 32'd0);
    check({tag, " m_valid"}, 32'(m_valid), 32'd0);
    check({tag, " m_last"}, 32'(m_last), 32'd0);
    check({tag, " m_data"}, 32'(m_data), 32'd0);
  endtask

  initial begin
    int t0, a0, b0, d0, mv0, n;
    for (int k = 0; k < 4096; k++) mem[k] = DW'(k - 100);

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;

    // A: linear burst of 8 from address 0, ready held high
    a0 = addr_q.size(); b0 = data_q.size(); d0 = done_q.size();
    start_burst(12'd0, 12'd8, 1'b0, t0);
    wait_done(d0, 100, "A");
    check_burst("A", a0, b0, 8, 12'd0, 1'b0);
    if (addr_q.size() > a0) check("A first cs cycle", 32'(addr_cyc_q[a0] - t0), 32'd1);
    if (data_q.size() >= b0 + 8) begin
      check("A first beat cycle", 32'(beat_cyc_q[b0] - t0), 32'd3);
      check("A last beat cycle", 32'(beat_cyc_q[b0+7] - t0), 32'd10);
      check("A beat1 value", 32'(data_q[b0]), 32'h9c);
      check("A beat8 value", 32'(data_q[b0+7]), 32'ha3);
    end
    if (done_q.size() > d0) check("A done cycle", 32'(done_q[d0] - t0), 32'd11);

    // B: full 2048-point bit-reversed burst
    a0 = addr_q.size(); b0 = data_q.size(); d0 = done_q.size();
    start_burst(12'd0, 12'd2048, 1'b1, t0);
    wait_done(d0, 3000, "B");
    check_burst("B", a0, b0, 2048, 12'd0, 1'b1);
    if (addr_q.size() >= a0 + 2048) begin
      check("B addr1", 32'(addr_q[a0+1]), 32'd1024);
      check("B addr2", 32'(addr_q[a0+2]), 32'd512);
      check("B addr3", 32'(addr_q[a0+3]), 32'd1536);
      check("B addr4", 32'(addr_q[a0+4]), 32'd256);
      check("B last addr", 32'(addr_q[a0+2047]), 32'd2047);
    end
    if (done_q.size() > d0) check("B done cycle", 32'(done_q[d0] - t0), 32'd2051);

    // C: address wrap at the top of the SRAM
    a0 = addr_q.size(); b0 = data_q.size(); d0 = done_q.size();
    start_burst(12'd4094, 12'd4, 1'b0, t0);
    wait_done(d0, 100, "C");
    check_burst("C", a0, b0, 4, 12'd4094, 1'b0);
    if (addr_q.size() >= a0 + 4) begin
      check("C addr0", 32'(addr_q[a0]), 32'd4094);
      check("C addr1", 32'(addr_q[a0+1]), 32'd4095);
      check("C addr2", 32'(addr_q[a0+2]), 32'd0);
      check("C addr3", 32'(addr_q[a0+3]), 32'd1);
    end

    // D: 16 words under random backpressure
    rand_ready = 1'b1;
    a0 = addr_q.size(); b0 = data_q.size(); d0 = done_q.size();
    start_burst(12'd300, 12'd16, 1'b0, t0);
    wait_done(d0, 2000, "D");
    rand_ready = 1'b0;
    check_burst("D", a0, b0, 16, 12'd300, 1'b0);
    check("D outstanding within 4", 32'(max_out <= 4), 32'd1);

    // E: zero-length request, then a start while busy
    a0 = addr_q.size(); b0 = data_q.size(); d0 = done_q.size(); mv0 = mv_cycles;
    start_burst(12'd5, 12'd0, 1'b0, t0);
    repeat (3) @(negedge clk);
    check("E0 done pulses", 32'(done_q.size() - d0), 32'd1);
    if (done_q.size() > d0) check("E0 done cycle", 32'(done_q[d0] - t0), 32'd1);
    check("E0 issues", 32'(addr_q.size() - a0), 32'd0);
    check("E0 valid cycles", 32'(mv_cycles - mv0), 32'd0);

    a0 = addr_q.size(); b0 = data_q.size(); d0 = done_q.size();
    start_burst(12'd100, 12'd8, 1'b0, t0);
    @(posedge clk);
    #1;
    base_addr = 12'd0;
    count     = 12'd3;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(d0, 100, "E1");
    repeat (6) @(negedge clk);
    check_burst("E1", a0, b0, 8, 12'd100, 1'b0);
    check("E1 done pulses", 32'(done_q.size() - d0), 32'd1);

    // F: reset after 3 beats, then a clean burst
    a0 = addr_q.size(); b0 = data_q.size();
    start_burst(12'd0, 12'd8, 1'b0, t0);
    n = 0;
    while (data_q.size() - b0 < 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("F three beats seen", 32'(data_q.size() - b0 >= 3), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_idle_outputs("F abort");
    rst = 1'b0;
    a0 = addr_q.size(); d0 = done_q.size(); mv0 = mv_cycles;
    repeat (6) @(negedge clk);
    check("F no done after abort", 32'(done_q.size() - d0), 32'd0);
    check("F no issue after abort", 32'(addr_q.size() - a0), 32'd0);
    check("F no valid after abort", 32'(mv_cycles - mv0), 32'd0);

    a0 = addr_q.size(); b0 = data_q.size(); d0 = done_q.size();
    start_burst(12'd10, 12'd8, 1'b0, t0);
    wait_done(d0, 100, "F2");
    check_burst("F2", a0, b0, 8, 12'd10, 1'b0);
    if (done_q.size() > d0) check("F2 done cycle", 32'(done_q[d0] - t0), 32'd11);

    // Whole-run properties
    check("sram_w never set", 32'(w_err), 32'd0);
    check("stable under backpressure", 32'(stab_err), 32'd0);
    check("done only while idle", 32'(done_busy_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
